// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state and bus-source encodings.
package fetch_sequencer_pkg;

   localparam int MAX_STEPS = 8;
   localparam int STEP_W    = $clog2(MAX_STEPS);

   typedef enum logic [1:0] {
      ST_FETCH0 = 2'd0,
      ST_FETCH1 = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALT   = 2'd3
   } seq_state_t;

   typedef enum logic [1:0] {
      BUS_NONE = 2'd0,
      BUS_PC   = 2'd1,
      BUS_MEM  = 2'd2,
      BUS_ALU  = 2'd3
   } bus_src_t;

   typedef struct packed {
      logic pc_en;
      logic mem_en;
      logic alu_en;
   } bus_drv_t;

endpackage

// File: rtl/fetch_sequencer_bus_src_decode.sv
// Bus driver selection: at most one of pc_en/mem_en/alu_en is set per cycle.
import fetch_sequencer_pkg::*;

module bus_src_decode (
   input  logic       en,
   input  seq_state_t state,
   input  logic [1:0] ex_bus_src,
   output bus_drv_t   drv
);

   always_comb begin
      drv = '0;
      if (en) begin
         unique case (state)
            ST_FETCH0: drv.pc_en  = 1'b1;
            ST_FETCH1: drv.mem_en = 1'b1;
            ST_EXEC: begin
               unique case (bus_src_t'(ex_bus_src))
                  BUS_PC:   drv.pc_en  = 1'b1;
                  BUS_MEM:  drv.mem_en = 1'b1;
                  BUS_ALU:  drv.alu_en = 1'b1;
                  BUS_NONE: drv        = '0;
               endcase
            end
            ST_HALT: drv = '0;
         endcase
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// T-state sequencer for PC/AR/IR/memory strobes and shared-bus driver selection.
import fetch_sequencer_pkg::*;

module fetch_sequencer #(
   parameter int MAX_STEPS = fetch_sequencer_pkg::MAX_STEPS,
   parameter int STEP_W    = fetch_sequencer_pkg::STEP_W
) (
   input  logic              clk,
   input  logic              reset_bar,
   input  logic              halt_req,
   input  logic              run,
   input  logic              ex_done,
   input  logic              ex_pc_load,
   input  logic              jump_cond,
   input  logic [1:0]        ex_bus_src,
   output logic              pc_load,
   output logic              pc_en,
   output logic              pc_inc,
   output logic              ar_load,
   output logic              ir_load,
   output logic              mem_en,
   output logic              alu_en,
   output logic [STEP_W-1:0] step,
   output logic              halted,
   output logic              step_ovf
);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

   seq_state_t        state, state_nx;
   logic [STEP_W-1:0] step_nx;
   logic              ovf_set;
   logic              last_step;
   bus_drv_t          drv;

   always_ff @(posedge clk) begin
      if (!reset_bar) begin
         state    <= ST_FETCH0;
         step     <= '0;
         step_ovf <= 1'b0;
      end else begin
         state <= state_nx;
         step  <= step_nx;
         if (ovf_set)
            step_ovf <= 1'b1;
      end
   end

   assign last_step = (step == LAST_STEP);

   always_comb begin
      state_nx = state;
      step_nx  = step;
      ovf_set  = 1'b0;
      unique case (state)
         ST_FETCH0: begin
            state_nx = ST_FETCH1;
            step_nx  = STEP_W'(1);
         end
         ST_FETCH1: begin
            state_nx = ST_EXEC;
            step_nx  = STEP_W'(2);
         end
         ST_EXEC: begin
            // the counter never wraps: the last step is a forced boundary
            if (ex_done || last_step) begin
               state_nx = halt_req ? ST_HALT : ST_FETCH0;
               step_nx  = '0;
               ovf_set  = !ex_done;
            end else begin
               step_nx = step + STEP_W'(1);
            end
         end
         ST_HALT: begin
            step_nx = '0;
            if (run)
               state_nx = ST_FETCH0;
         end
      endcase
   end

   bus_src_decode u_bus (
      .en         (reset_bar),
      .state      (state),
      .ex_bus_src (ex_bus_src),
      .drv        (drv)
   );

   always_comb begin
      pc_load = 1'b0;
      pc_inc  = 1'b0;
      ar_load = 1'b0;
      ir_load = 1'b0;
      if (reset_bar) begin
         unique case (state)
            ST_FETCH0: ar_load = 1'b1;
            ST_FETCH1: begin
               ir_load = 1'b1;
               pc_inc  = 1'b1;
            end
            ST_EXEC: begin
               // PC cannot both drive the bus and load from it
               pc_load = ex_pc_load & jump_cond &
                         (bus_src_t'(ex_bus_src) != BUS_PC);
            end
            ST_HALT: pc_load = 1'b0;
         endcase
      end
   end

   assign pc_en  = drv.pc_en;
   assign mem_en = drv.mem_en;
   assign alu_en = drv.alu_en;
   assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector table plus hand sequences and random invariant checks.
module tb_fetch_sequencer;

   logic       clk = 1'b0;
   logic       reset_bar;
   logic       halt_req, run, ex_done, ex_pc_load, jump_cond;
   logic [1:0] ex_bus_src;
   logic       pc_load, pc_en, pc_inc, ar_load, ir_load;
   logic       mem_en, alu_en, halted, step_ovf;
   logic [2:0] step;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk        (clk),
      .reset_bar  (reset_bar),
      .halt_req   (halt_req),
      .run        (run),
      .ex_done    (ex_done),
      .ex_pc_load (ex_pc_load),
      .jump_cond  (jump_cond),
      .ex_bus_src (ex_bus_src),
      .pc_load    (pc_load),
      .pc_en      (pc_en),
      .pc_inc     (pc_inc),
      .ar_load    (ar_load),
      .ir_load    (ir_load),
      .mem_en     (mem_en),
      .alu_en     (alu_en),
      .step       (step),
      .halted     (halted),
      .step_ovf   (step_ovf)
   );

   // {pc_load,pc_en,pc_inc,ar_load,ir_load,mem_en,alu_en,halted,step_ovf}
   logic [8:0] o;
   assign o = {pc_load, pc_en, pc_inc, ar_load, ir_load,
               mem_en, alu_en, halted, step_ovf};

   localparam logic [8:0] F0   = 9'b010100000;
   localparam logic [8:0] F1   = 9'b001011000;
   localparam logic [8:0] NONE = 9'b000000000;
   localparam logic [8:0] HLT  = 9'b000000010;
   localparam logic [8:0] OVF  = 9'b000000001;

   typedef struct {
      logic       hr, rn, dn, pl, jc;
      logic [1:0] src;
      logic [2:0] st;
      logic [8:0] ex;
   } vec_t;

   vec_t vt [21];

   function automatic vec_t mk(logic hr, logic rn, logic dn, logic pl,
                               logic jc, logic [1:0] src,
                               logic [2:0] st, logic [8:0] ex);
      vec_t v;
      v.hr = hr; v.rn = rn; v.dn = dn; v.pl = pl; v.jc = jc;
      v.src = src; v.st = st; v.ex = ex;
      return v;
   endfunction

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(logic hr, logic rn, logic dn, logic pl,
                        logic jc, logic [1:0] src);
      halt_req = hr; run = rn; ex_done = dn;
      ex_pc_load = pl; jump_cond = jc; ex_bus_src = src;
   endtask

   task automatic cyc(logic hr, logic rn, logic dn, logic pl,
                      logic jc, logic [1:0] src);
      @(negedge clk);
      drive(hr, rn, dn, pl, jc, src);
      #1;
   endtask

   initial begin
      // hr rn dn pl jc src step expected
      vt[0]  = mk(0,0,0,0,0,2'd0, 3'd0, F0);
      vt[1]  = mk(0,0,0,0,0,2'd0, 3'd1, F1);
      vt[2]  = mk(0,0,1,0,0,2'd2, 3'd2, 9'b000001000);
      vt[3]  = mk(0,0,0,0,0,2'd0, 3'd0, F0);
      vt[4]  = mk(0,0,0,0,0,2'd0, 3'd1, F1);
      vt[5]  = mk(0,0,0,0,0,2'd0, 3'd2, NONE);
      vt[6]  = mk(0,0,1,1,1,2'd3, 3'd3, 9'b100000100);
      vt[7]  = mk(0,0,0,0,0,2'd0, 3'd0, F0);
      vt[8]  = mk(0,0,0,0,0,2'd0, 3'd1, F1);
      vt[9]  = mk(0,0,0,0,0,2'd1, 3'd2, 9'b010000000);
      vt[10] = mk(0,0,1,1,0,2'd3, 3'd3, 9'b000000100);
      vt[11] = mk(0,0,0,0,0,2'd0, 3'd0, F0);
      vt[12] = mk(1,0,0,0,0,2'd0, 3'd1, F1);
      vt[13] = mk(1,0,1,1,1,2'd1, 3'd2, 9'b010000000);
      vt[14] = mk(0,0,0,0,0,2'd0, 3'd0, HLT);
      vt[15] = mk(0,0,1,1,1,2'd3, 3'd0, HLT);
      vt[16] = mk(0,1,0,0,0,2'd0, 3'd0, HLT);
      vt[17] = mk(0,0,0,0,0,2'd0, 3'd0, F0);
      vt[18] = mk(0,1,0,0,0,2'd0, 3'd1, F1);
      vt[19] = mk(0,0,1,0,0,2'd0, 3'd2, NONE);
      vt[20] = mk(0,0,0,0,0,2'd0, 3'd0, F0);

      reset_bar = 1'b0;
      drive(0,0,0,0,0,2'd0);
      #1;
      chk("strobes in reset", 16'(o[8:2]), 16'd0);
      @(posedge clk);
      @(negedge clk);
      reset_bar = 1'b1;

      for (int i = 0; i < 21; i++) begin
         if (i > 0) @(negedge clk);
         drive(vt[i].hr, vt[i].rn, vt[i].dn, vt[i].pl,
               vt[i].jc, vt[i].src);
         #1;
         chk($sformatf("vec%0d step", i), 16'(step), 16'(vt[i].st));
         chk($sformatf("vec%0d outs", i), 16'(o), 16'(vt[i].ex));
      end

      // ex_done never asserted: forced boundary after step 7
      for (int s = 1; s < 8; s++) begin
         cyc(0,0,0,0,0,2'd0);
         chk($sformatf("ovf run step%0d", s), 16'(step), 16'(s));
         chk($sformatf("ovf run flag%0d", s), 16'(step_ovf), 16'd0);
      end
      cyc(0,0,0,0,0,2'd0);
      chk("ovf boundary step", 16'(step), 16'd0);
      chk("ovf boundary outs", 16'(o), 16'(F0 | OVF));
      cyc(0,0,0,0,0,2'd0);
      cyc(0,0,1,0,0,2'd0);
      chk("ovf normal instr step", 16'(step), 16'd2);
      cyc(0,0,0,0,0,2'd0);
      chk("ovf sticky", 16'(o), 16'(F0 | OVF));

      // halt_req held across a forced boundary
      cyc(1,0,0,0,0,2'd0);
      chk("halt fetch1 outs", 16'(o), 16'(F1 | OVF));
      for (int s = 2; s < 8; s++) begin
         cyc(1,0,0,0,0,2'd0);
         chk($sformatf("halt run step%0d", s), 16'(step), 16'(s));
      end
      cyc(0,0,0,0,0,2'd3);
      chk("forced halt outs", 16'(o), 16'(HLT | OVF));
      chk("forced halt step", 16'(step), 16'd0);
      cyc(0,1,0,0,0,2'd0);
      cyc(0,0,0,0,0,2'd0);
      chk("resume outs", 16'(o), 16'(F0 | OVF));

      // random ex_* stimulus: bus exclusivity and PC strobe exclusivity
      for (int k = 0; k < 300; k++) begin
         cyc(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
         chk($sformatf("bus excl %0d", k),
             16'(int'(pc_en) + int'(mem_en) + int'(alu_en) > 1), 16'd0);
         chk($sformatf("pc excl %0d", k), 16'(pc_load & pc_inc), 16'd0);
      end

      // reset clears step_ovf and aborts an instruction mid-flight
      @(negedge clk);
      reset_bar = 1'b0;
      drive(0,0,0,0,0,2'd0);
      @(negedge clk);
      reset_bar = 1'b1;
      #1;
      chk("post reset outs", 16'(o), 16'(F0));
      cyc(0,0,0,0,0,2'd0);
      cyc(0,0,0,1,1,2'd3);
      chk("pre abort outs", 16'(o), 16'(9'b100000100));
      reset_bar = 1'b0;
      #1;
      chk("abort strobes", 16'(o[8:2]), 16'd0);
      @(negedge clk);
      #1;
      chk("in reset outs", 16'(o), 16'd0);
      chk("in reset step", 16'(step), 16'd0);
      reset_bar = 1'b1;
      #1;
      chk("after abort outs", 16'(o), 16'(F0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
